// File: rtl/lt24_pixel_writer_pkg.sv
// Shared LT24 command codes, FSM encoding and the setup-word table for the pixel writer.
package lt24_pixel_writer_pkg;

  localparam logic [7:0] CMD_COLADDR  = 8'h2A;
  localparam logic [7:0] CMD_PAGEADDR = 8'h2B;
  localparam logic [7:0] CMD_MEMWR    = 8'h2C;

  // Index of the pixel data word inside a full setup sequence (words 0..10 are setup).
  localparam logic [3:0] DATA_WORD_IDX = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DROP  = 2'd1,
    ST_SETUP = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  // Returns {rs, data} for word idx of a full window setup; idx >= 11 is the pixel itself.
  function automatic logic [16:0] setup_word(input logic [3:0]  idx,
                                             input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [15:0] x_end,
                                             input logic [15:0] y_end,
                                             input logic [15:0] pix);
    logic [16:0] w;
    case (idx)
      4'd0:    w = {1'b0, 8'h00, CMD_COLADDR};
      4'd1:    w = {1'b1, 8'h00, x[15:8]};
      4'd2:    w = {1'b1, 8'h00, x[7:0]};
      4'd3:    w = {1'b1, 8'h00, x_end[15:8]};
      4'd4:    w = {1'b1, 8'h00, x_end[7:0]};
      4'd5:    w = {1'b0, 8'h00, CMD_PAGEADDR};
      4'd6:    w = {1'b1, 8'h00, y[15:8]};
      4'd7:    w = {1'b1, 8'h00, y[7:0]};
      4'd8:    w = {1'b1, 8'h00, y_end[15:8]};
      4'd9:    w = {1'b1, 8'h00, y_end[7:0]};
      4'd10:   w = {1'b0, 8'h00, CMD_MEMWR};
      default: w = {1'b1, pix};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lt24_pixel_writer_bus_word.sv
// Emits one 8080 bus word: Wr_n low WR_LOW cycles then high WR_HIGH cycles, RS/Data held throughout.
module lt24_bus_word #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [16:0] word,
  output logic        busy,
  output logic        done,
  output logic        wr_n,
  output logic        rs,
  output logic [15:0] data
);
  localparam int P  = WR_LOW + WR_HIGH;
  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] LAST    = CW'(P - 1);
  localparam logic [CW-1:0] LOW_END = CW'(WR_LOW);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt;

  // done marks the final cycle of a word so the next word can start back-to-back.
  assign done = busy && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      wr_n <= 1'b1;
      rs   <= 1'b1;
      data <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      wr_n <= 1'b0;
      rs   <= word[16];
      data <= word[15:0];
    end else if (done) begin
      busy <= 1'b0;
      wr_n <= 1'b1;
    end else if (busy) begin
      cnt  <= cnt + ONE;
      wr_n <= ((cnt + ONE) >= LOW_END);
    end
  end

endmodule

// File: rtl/lt24_pixel_writer.sv
// Pixel-write responder: turns (x, y, colour) requests into LT24 window/data bus writes,
// skipping window setup when the pixel continues the panel's auto-increment.
module lt24_pixel_writer
  import lt24_pixel_writer_pkg::*;
#(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        initDone,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        pixelDropped,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data,
  output logic        LT24Reset_n,
  output logic        LT24LCDOn,
  output logic [1:0]  state_dbg
);
  // Handshake: a pixel transfers in any cycle where pixelWrite && pixelReady; pixelReady is a
  // registered "idle and init done" flag and drops the cycle after a transfer until the sequence ends.
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  state_t      state, state_next;
  logic [7:0]  x_q, pred_x, win_x0;
  logic [8:0]  y_q, pred_y;
  logic [15:0] pix_q;
  logic        pred_valid;
  logic [3:0]  word_idx;
  logic        accept, in_range, pred_hit;
  logic        bw_start, bw_busy, bw_done;
  logic [16:0] bw_word;

  assign accept   = pixelReady && pixelWrite && !bw_busy;
  assign in_range = (xAddr <= X_LAST) && (yAddr <= Y_LAST);
  assign pred_hit = pred_valid && (xAddr == pred_x) && (yAddr == pred_y);

  assign LT24Rd_n     = 1'b1;
  assign LT24Reset_n  = 1'b1;
  assign LT24LCDOn    = 1'b1;
  assign pixelDropped = (state == ST_DROP);
  assign state_dbg    = state;

  always_comb begin
    state_next = state;
    bw_start   = 1'b0;
    bw_word    = setup_word(word_idx, {8'h00, x_q}, {7'h00, y_q},
                            {8'h00, X_LAST}, {7'h00, Y_LAST}, pix_q);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            state_next = ST_DROP;
          end else if (pred_hit) begin
            state_next = ST_DATA;
            bw_start   = 1'b1;
            bw_word    = {1'b1, pixelData};
          end else begin
            state_next = ST_SETUP;
            bw_start   = 1'b1;
            bw_word    = {1'b0, 8'h00, CMD_COLADDR};
          end
        end
      end
      ST_DROP: state_next = ST_IDLE;
      ST_SETUP: begin
        if (bw_done) begin
          bw_start = 1'b1;
          if (word_idx == DATA_WORD_IDX) state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bw_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      pixelReady <= 1'b0;
      LT24CS_n   <= 1'b1;
      pred_valid <= 1'b0;
      pred_x     <= '0;
      pred_y     <= '0;
      win_x0     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= '0;
      word_idx   <= '0;
    end else begin
      state      <= state_next;
      pixelReady <= (state_next == ST_IDLE) && initDone;
      LT24CS_n   <= !((state_next == ST_SETUP) || (state_next == ST_DATA));
      if (accept) begin
        x_q      <= xAddr;
        y_q      <= yAddr;
        pix_q    <= pixelData;
        word_idx <= 4'd1;
        if (in_range && !pred_hit) win_x0 <= xAddr;
      end else if ((state == ST_SETUP) && bw_done) begin
        word_idx <= word_idx + 4'd1;
      end
      // Track the panel's auto-increment within the current window after each data word.
      if ((state == ST_DATA) && bw_done) begin
        if (x_q < X_LAST) begin
          pred_x     <= x_q + 8'd1;
          pred_y     <= y_q;
          pred_valid <= 1'b1;
        end else if (y_q < Y_LAST) begin
          pred_x     <= win_x0;
          pred_y     <= y_q + 9'd1;
          pred_valid <= 1'b1;
        end else begin
          pred_valid <= 1'b0;
        end
      end
    end
  end

  lt24_bus_word #(
    .WR_LOW (WR_LOW),
    .WR_HIGH(WR_HIGH)
  ) u_bus_word (
    .clock(clock),
    .reset(reset),
    .start(bw_start),
    .word (bw_word),
    .busy (bw_busy),
    .done (bw_done),
    .wr_n (LT24Wr_n),
    .rs   (LT24RS),
    .data (LT24Data)
  );

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Directed bench for lt24_pixel_writer: a raster/window model predicts bus words and latencies.
module tb_lt24_pixel_writer;
  localparam int WIDTH   = 240;
  localparam int HEIGHT  = 320;
  localparam int WR_LOW  = 2;
  localparam int WR_HIGH = 2;
  localparam int P       = WR_LOW + WR_HIGH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        initDone = 1'b0;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, pixelDropped;
  logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
  logic [15:0] LT24Data;
  logic        LT24Reset_n, LT24LCDOn;
  logic [1:0]  state_dbg;

  lt24_pixel_writer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)
  ) dut (
    .clock(clock), .reset(reset), .initDone(initDone),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .pixelDropped(pixelDropped),
    .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS),
    .LT24Data(LT24Data), .LT24Reset_n(LT24Reset_n), .LT24LCDOn(LT24LCDOn),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          words_seen = 0;
  logic        exp_drop = 1'b0;
  int          exp_lat  = 0;

  // Window model: next expected (x,y) of the panel's auto-increment
  logic m_valid = 1'b0;
  int   m_x = 0, m_y = 0, m_x0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic rs, input int v);
    exp_q.push_back({rs, v[15:0]});
  endtask

  task automatic model_accept(input int x, input int y, input logic [15:0] d);
    exp_drop = 1'b0;
    if (x >= WIDTH || y >= HEIGHT) begin
      exp_drop = 1'b1;
      exp_lat  = 2;
      return;
    end
    if (m_valid && x == m_x && y == m_y) begin
      exp_lat = 1 + P;
    end else begin
      m_x0 = x;
      push_word(1'b0, 'h2A);
      push_word(1'b1, x / 256);            push_word(1'b1, x % 256);
      push_word(1'b1, (WIDTH - 1) / 256);  push_word(1'b1, (WIDTH - 1) % 256);
      push_word(1'b0, 'h2B);
      push_word(1'b1, y / 256);            push_word(1'b1, y % 256);
      push_word(1'b1, (HEIGHT - 1) / 256); push_word(1'b1, (HEIGHT - 1) % 256);
      push_word(1'b0, 'h2C);
      exp_lat = 1 + 12 * P;
    end
    push_word(1'b1, int'(d));
    if (x < WIDTH - 1) begin
      m_x = x + 1; m_y = y; m_valid = 1'b1;
    end else if (y < HEIGHT - 1) begin
      m_x = m_x0; m_y = y + 1; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // Compare process: bus protocol and word contents, sampled on the falling clock edge
  logic        prev_wr = 1'b1;
  int          low_cnt = 0;
  logic [16:0] cur_word = '0;

  always @(negedge clock) begin
    if (reset) begin
      prev_wr = 1'b1;
      low_cnt = 0;
    end else begin
      check("rd_n_high", LT24Rd_n, 1'b1);
      if (LT24CS_n) check("wr_n_idle_when_deselected", LT24Wr_n, 1'b1);
      if (pixelReady) check("bus_idle_when_ready", {LT24CS_n, LT24Wr_n}, 2'b11);
      if (prev_wr && !LT24Wr_n) begin
        cur_word = {LT24RS, LT24Data};
        words_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", cur_word, $time);
        end else begin
          check("bus_word", cur_word, exp_q.pop_front());
        end
        low_cnt = 1;
      end else if (!LT24Wr_n) begin
        low_cnt++;
      end
      if (!prev_wr && LT24Wr_n) begin
        check("wr_low_len", low_cnt, WR_LOW);
        check("word_stable", {LT24RS, LT24Data}, cur_word);
      end
      prev_wr = LT24Wr_n;
    end
  end

  // Driver tasks
  task automatic start_pixel(input int x, input int y, input logic [15:0] d);
    int g;
    g = 0;
    @(negedge clock);
    while (!pixelReady && g < 200) begin
      @(negedge clock);
      g++;
    end
    check("ready_before_write", pixelReady, 1'b1);
    model_accept(x, y, d);
    xAddr      = x[7:0];
    yAddr      = y[8:0];
    pixelData  = d;
    pixelWrite = 1'b1;
    @(posedge clock);
    #1 pixelWrite = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      check("dropped_pulse", pixelDropped, (exp_drop && n == 1));
    end while (!pixelReady && n < 200);
    check("latency", n, exp_lat);
  endtask

  task automatic write_pixel(input int x, input int y, input logic [15:0] d, output int n);
    start_pixel(x, y, d);
    wait_ready(n);
  endtask

  // Stimulus
  logic [16:0] lit_words [12];
  int lat;
  int seen0;

  initial begin
    lit_words = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h100EF, 17'h0002B,
                  17'h10000, 17'h10014, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};

    // Reset values and initDone gating
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", pixelReady, 1'b0);
    check("rst_cs_n", LT24CS_n, 1'b1);
    check("rst_wr_n", LT24Wr_n, 1'b1);
    check("rst_rd_n", LT24Rd_n, 1'b1);
    check("rst_rs", LT24RS, 1'b1);
    check("rst_data", LT24Data, 16'h0000);
    check("rst_dropped", pixelDropped, 1'b0);
    check("lcd_reset_n", LT24Reset_n, 1'b1);
    check("lcd_on", LT24LCDOn, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    xAddr = 8'd10; yAddr = 9'd20; pixelData = 16'hFFFF; pixelWrite = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("no_init_ready", pixelReady, 1'b0);
      check("no_init_cs_n", LT24CS_n, 1'b1);
    end
    pixelWrite = 1'b0;
    initDone   = 1'b1;
    repeat (2) @(negedge clock);
    check("init_ready", pixelReady, 1'b1);

    // Full setup for (10,20)
    start_pixel(10, 20, 16'hF800);
    check("model_full_len", exp_q.size(), 12);
    for (int i = 0; i < 12; i++) check("model_full_word", exp_q[i], lit_words[i]);
    wait_ready(lat);
    check("full_latency_49", lat, 49);

    // Continuation (11,20) is a single data word
    write_pixel(11, 20, 16'h07E0, lat);
    check("fast_latency_5", lat, 5);

    // Stream to the right edge, wrap to window start column, then a fresh window
    for (int x = 12; x < WIDTH; x++) write_pixel(x, 20, 16'(x * 3), lat);
    write_pixel(10, 21, 16'h1234, lat);
    check("wrap_fast_5", lat, 5);
    write_pixel(0, 22, 16'h0F0F, lat);
    check("new_window_49", lat, 49);
    write_pixel(1, 22, 16'hA5A5, lat);
    check("after_new_window_5", lat, 5);

    // Out-of-range pixels are dropped without disturbing the prediction
    write_pixel(240, 5, 16'hDEAD, lat);
    check("drop_x_latency_2", lat, 2);
    write_pixel(3, 320, 16'hBEEF, lat);
    check("drop_y_latency_2", lat, 2);
    write_pixel(2, 22, 16'h5A5A, lat);
    check("post_drop_fast_5", lat, 5);

    // Bottom-right corner invalidates the prediction
    write_pixel(239, 319, 16'h0001, lat);
    write_pixel(0, 0, 16'h0002, lat);
    check("after_corner_full_49", lat, 49);

    // Reset during the sixth setup word abandons the pixel
    seen0 = words_seen;
    start_pixel(10, 20, 16'h1111);
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midreset_cs_n", LT24CS_n, 1'b1);
    check("midreset_wr_n", LT24Wr_n, 1'b1);
    check("midreset_words_before", words_seen - seen0, 5);
    exp_q.delete();
    m_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    write_pixel(11, 20, 16'h2222, lat);
    check("post_reset_full_49", lat, 49);

    repeat (4) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
